// File: rtl/pll_reset_ctrl.sv
// PLL reset sequencer: timed reset pulse, lock wait with timeout, lock glitch
// filter, bounded retries, and relock on lock loss.
module pll_reset_ctrl #(
    parameter int unsigned HOLD_CYCLES  = 16,
    parameter int unsigned LOCK_TIMEOUT = 65535,
    parameter int unsigned LOCK_FILT    = 8,
    parameter int unsigned MAX_RETRY    = 3,
    localparam int unsigned RETRY_W     = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    input  logic               locked_i,
    input  logic               restart_i,
    output logic               pll_rst_o,
    output logic               pll_ready_o,
    output logic               fail_o,
    output logic [RETRY_W-1:0] retry_cnt_o,
    output logic [2:0]         state_o
);

    localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int unsigned TMO_W  = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
    localparam int unsigned FILT_W = (LOCK_FILT > 1) ? $clog2(LOCK_FILT) : 1;
    // With a single-sample filter the FILTER entry sample already qualifies lock.
    localparam bit DIRECT_RUN = (LOCK_FILT == 1);

    typedef enum logic [2:0] {
        S_HOLD   = 3'd0,
        S_WAIT   = 3'd1,
        S_FILTER = 3'd2,
        S_RUN    = 3'd3,
        S_FAIL   = 3'd4
    } state_t;

    state_t              state, state_n;
    logic [1:0]          sync_q;
    logic                locked_s;
    logic [HOLD_W-1:0]   hold_cnt, hold_n;
    logic [TMO_W-1:0]    tmo_cnt, tmo_n;
    logic [FILT_W-1:0]   filt_cnt, filt_n;
    logic [RETRY_W-1:0]  retry_n;
    logic                hold_last, tmo_last, filt_last, tmo_hit;

    assign locked_s  = sync_q[1];
    assign state_o   = state;
    assign hold_last = (hold_cnt == HOLD_W'(HOLD_CYCLES - 1));
    assign tmo_last  = (tmo_cnt == TMO_W'(LOCK_TIMEOUT - 1));
    // The FILTER entry edge is the first qualified sample, so completion is one count early.
    assign filt_last = ((32'(filt_cnt) + 32'd1) == (LOCK_FILT - 32'd1));

    // Next-state and next-counter decode
    always_comb begin
        state_n = state;
        hold_n  = hold_cnt;
        tmo_n   = tmo_cnt;
        filt_n  = filt_cnt;
        retry_n = retry_cnt_o;
        tmo_hit = 1'b0;

        case (state)
            S_HOLD: begin
                if (hold_last) begin
                    state_n = S_WAIT;
                    tmo_n   = '0;
                end else begin
                    hold_n = hold_cnt + HOLD_W'(1);
                end
            end
            S_WAIT: begin
                tmo_n = tmo_last ? tmo_cnt : tmo_cnt + TMO_W'(1);
                if (locked_s && DIRECT_RUN) begin
                    state_n = S_RUN;
                end else if (tmo_last) begin
                    tmo_hit = 1'b1;
                end else if (locked_s) begin
                    state_n = S_FILTER;
                    filt_n  = '0;
                end
            end
            S_FILTER: begin
                tmo_n = tmo_last ? tmo_cnt : tmo_cnt + TMO_W'(1);
                if (locked_s && filt_last) begin
                    state_n = S_RUN;
                end else if (tmo_last) begin
                    tmo_hit = 1'b1;
                end else if (!locked_s) begin
                    state_n = S_WAIT;
                end else begin
                    filt_n = filt_cnt + FILT_W'(1);
                end
            end
            S_RUN: begin
                if (!locked_s) begin
                    state_n = S_HOLD;
                    hold_n  = '0;
                    retry_n = '0;
                end
            end
            S_FAIL: begin
                state_n = S_FAIL;
            end
            default: begin
                state_n = S_HOLD;
                hold_n  = '0;
            end
        endcase

        if (tmo_hit) begin
            tmo_n  = '0;
            hold_n = '0;
            if (retry_cnt_o < RETRY_W'(MAX_RETRY)) begin
                retry_n = retry_cnt_o + RETRY_W'(1);
                state_n = S_HOLD;
            end else begin
                state_n = S_FAIL;
            end
        end

        if (restart_i) begin
            state_n = S_HOLD;
            hold_n  = '0;
            tmo_n   = '0;
            filt_n  = '0;
            retry_n = '0;
        end
    end

    // State, counters, synchronizer and outputs decoded from the next state
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sync_q      <= '0;
            state       <= S_HOLD;
            hold_cnt    <= '0;
            tmo_cnt     <= '0;
            filt_cnt    <= '0;
            retry_cnt_o <= '0;
            pll_rst_o   <= 1'b1;
            pll_ready_o <= 1'b0;
            fail_o      <= 1'b0;
        end else begin
            sync_q      <= {sync_q[0], locked_i};
            state       <= state_n;
            hold_cnt    <= hold_n;
            tmo_cnt     <= tmo_n;
            filt_cnt    <= filt_n;
            retry_cnt_o <= retry_n;
            pll_rst_o   <= (state_n == S_HOLD) || (state_n == S_FAIL);
            pll_ready_o <= (state_n == S_RUN);
            fail_o      <= (state_n == S_FAIL);
        end
    end

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// Scoreboard bench for pll_reset_ctrl: stimulus queues edge-stamped expected
// outputs, a negedge monitor pops and compares them.
module tb_pll_reset_ctrl;

    localparam int unsigned HOLD = 4;
    localparam int unsigned TMO  = 20;
    localparam int unsigned FILT = 3;
    localparam int unsigned MAXR = 2;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       locked = 1'b0;
    logic       restart = 1'b0;
    logic       pll_rst, pll_ready, fail;
    logic [1:0] retry;
    logic [2:0] st;

    int edge_n  = 0;
    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        int         e;
        string      tag;
        logic [7:0] v;
    } rec_t;

    rec_t sb[$];

    pll_reset_ctrl #(
        .HOLD_CYCLES (HOLD),
        .LOCK_TIMEOUT(TMO),
        .LOCK_FILT   (FILT),
        .MAX_RETRY   (MAXR)
    ) dut (
        .clk_i      (clk),
        .rstn_i     (rstn),
        .locked_i   (locked),
        .restart_i  (restart),
        .pll_rst_o  (pll_rst),
        .pll_ready_o(pll_ready),
        .fail_o     (fail),
        .retry_cnt_o(retry),
        .state_o    (st)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_n <= edge_n + 1;

    function automatic void expect_at(input int e, input string tag, input logic [2:0] s,
                                      input logic r, input logic rd, input logic f,
                                      input logic [1:0] rc);
        rec_t x;
        x.e   = e;
        x.tag = tag;
        x.v   = {s, r, rd, f, rc};
        sb.push_back(x);
    endfunction

    // Monitor: compare every record due at or before the edge just passed
    always @(negedge clk) begin
        logic [7:0] act;
        rec_t       x;
        act = {st, pll_rst, pll_ready, fail, retry};
        while (sb.size() > 0 && sb[0].e <= edge_n) begin
            x = sb.pop_front();
            n_total++;
            if (x.e == edge_n && act == x.v) begin
                n_pass++;
            end else begin
                $display("FAIL %s at edge %0d (due %0d): got state=%0d rst=%b rdy=%b fail=%b retry=%0d, required state=%0d rst=%b rdy=%b fail=%b retry=%0d",
                         x.tag, edge_n, x.e, act[7:5], act[4], act[3], act[2], act[1:0],
                         x.v[7:5], x.v[4], x.v[3], x.v[2], x.v[1:0]);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    initial begin
        #40000;
        $display("FAIL watchdog: simulation time limit reached at edge %0d", edge_n);
        $fatal(1, "watchdog");
    end

    initial begin
        int   b;
        rec_t x;

        // Reset values while rstn is held low
        steps(2);
        expect_at(edge_n, "reset_vals", 3'd0, 1'b1, 1'b0, 1'b0, 2'd0);
        step();

        // Clean lock: pll_rst falls at edge 4, ready 4 edges after first high sample
        rstn = 1'b1;
        b = edge_n;
        expect_at(b + 3, "hold_last", 3'd0, 1'b1, 1'b0, 1'b0, 2'd0);
        expect_at(b + 4, "rst_fall", 3'd1, 1'b0, 1'b0, 1'b0, 2'd0);
        steps(8);
        locked = 1'b1;
        expect_at(b + 10, "sync_wait", 3'd1, 1'b0, 1'b0, 1'b0, 2'd0);
        expect_at(b + 11, "filter_in", 3'd2, 1'b0, 1'b0, 1'b0, 2'd0);
        expect_at(b + 12, "filter_mid", 3'd2, 1'b0, 1'b0, 1'b0, 2'd0);
        expect_at(b + 13, "ready_rise", 3'd3, 1'b0, 1'b1, 1'b0, 2'd0);
        steps(7);

        // Lock loss, one timed-out attempt, then a filter glitch before relock
        b = edge_n;
        locked = 1'b0;
        expect_at(b + 2, "loss_wait", 3'd3, 1'b0, 1'b1, 1'b0, 2'd0);
        expect_at(b + 3, "loss_hold", 3'd0, 1'b1, 1'b0, 1'b0, 2'd0);
        expect_at(b + 7, "loss_wait_lock", 3'd1, 1'b0, 1'b0, 1'b0, 2'd0);
        expect_at(b + 26, "pre_timeout", 3'd1, 1'b0, 1'b0, 1'b0, 2'd0);
        expect_at(b + 27, "timeout_1", 3'd0, 1'b1, 1'b0, 1'b0, 2'd1);
        expect_at(b + 31, "retry1_wait", 3'd1, 1'b0, 1'b0, 1'b0, 2'd1);
        steps(31);
        b = edge_n;
        locked = 1'b1;
        expect_at(b + 3, "g_filter", 3'd2, 1'b0, 1'b0, 1'b0, 2'd1);
        expect_at(b + 4, "g_filter2", 3'd2, 1'b0, 1'b0, 1'b0, 2'd1);
        expect_at(b + 5, "g_back_wait", 3'd1, 1'b0, 1'b0, 1'b0, 2'd1);
        expect_at(b + 6, "g_refilter", 3'd2, 1'b0, 1'b0, 1'b0, 2'd1);
        expect_at(b + 7, "g_no_early_rdy", 3'd2, 1'b0, 1'b0, 1'b0, 2'd1);
        expect_at(b + 8, "g_ready", 3'd3, 1'b0, 1'b1, 1'b0, 2'd1);
        steps(2);
        locked = 1'b0;
        step();
        locked = 1'b1;
        steps(7);

        // Lock loss in RUN clears the retry count, then relock
        b = edge_n;
        expect_at(b, "run_retry1", 3'd3, 1'b0, 1'b1, 1'b0, 2'd1);
        locked = 1'b0;
        expect_at(b + 2, "run_hold_on", 3'd3, 1'b0, 1'b1, 1'b0, 2'd1);
        expect_at(b + 3, "run_loss", 3'd0, 1'b1, 1'b0, 1'b0, 2'd0);
        expect_at(b + 6, "relock_hold", 3'd0, 1'b1, 1'b0, 1'b0, 2'd0);
        expect_at(b + 7, "relock_wait", 3'd1, 1'b0, 1'b0, 1'b0, 2'd0);
        expect_at(b + 10, "relock_filter", 3'd2, 1'b0, 1'b0, 1'b0, 2'd0);
        expect_at(b + 11, "relock_filter2", 3'd2, 1'b0, 1'b0, 1'b0, 2'd0);
        expect_at(b + 12, "relock_ready", 3'd3, 1'b0, 1'b1, 1'b0, 2'd0);
        steps(7);
        locked = 1'b1;
        steps(7);

        // Reach FILTER again, then assert async reset between edges
        b = edge_n;
        locked = 1'b0;
        expect_at(b + 2, "d_run", 3'd3, 1'b0, 1'b1, 1'b0, 2'd0);
        expect_at(b + 3, "d_hold", 3'd0, 1'b1, 1'b0, 1'b0, 2'd0);
        expect_at(b + 7, "d_wait", 3'd1, 1'b0, 1'b0, 1'b0, 2'd0);
        expect_at(b + 9, "d_wait2", 3'd1, 1'b0, 1'b0, 1'b0, 2'd0);
        expect_at(b + 10, "d_filter", 3'd2, 1'b0, 1'b0, 1'b0, 2'd0);
        steps(7);
        locked = 1'b1;
        steps(4);
        rstn   = 1'b0;
        locked = 1'b0;
        expect_at(edge_n, "async_reset", 3'd0, 1'b1, 1'b0, 1'b0, 2'd0);
        #1;
        n_total++;
        if (st == 3'd0) n_pass++;
        else $display("FAIL async_state: got %0d, required 0 with no clock edge", st);
        n_total++;
        if (pll_rst == 1'b1) n_pass++;
        else $display("FAIL async_pll_rst: got %b, required 1 with no clock edge", pll_rst);
        n_total++;
        if (pll_ready == 1'b0) n_pass++;
        else $display("FAIL async_pll_ready: got %b, required 0 with no clock edge", pll_ready);
        n_total++;
        if (fail == 1'b0) n_pass++;
        else $display("FAIL async_fail: got %b, required 0 with no clock edge", fail);
        n_total++;
        if (retry == 2'd0) n_pass++;
        else $display("FAIL async_retry: got %0d, required 0 with no clock edge", retry);
        steps(2);

        // Full sequence after release, no lock ever: retries then FAIL at 72
        rstn = 1'b1;
        b = edge_n;
        expect_at(b + 3, "r2_hold", 3'd0, 1'b1, 1'b0, 1'b0, 2'd0);
        expect_at(b + 4, "r2_rst_fall", 3'd1, 1'b0, 1'b0, 1'b0, 2'd0);
        expect_at(b + 23, "r2_pre_to1", 3'd1, 1'b0, 1'b0, 1'b0, 2'd0);
        expect_at(b + 24, "r2_retry1", 3'd0, 1'b1, 1'b0, 1'b0, 2'd1);
        expect_at(b + 28, "r2_wait2", 3'd1, 1'b0, 1'b0, 1'b0, 2'd1);
        expect_at(b + 48, "r2_retry2", 3'd0, 1'b1, 1'b0, 1'b0, 2'd2);
        expect_at(b + 52, "r2_wait3", 3'd1, 1'b0, 1'b0, 1'b0, 2'd2);
        expect_at(b + 71, "r2_pre_fail", 3'd1, 1'b0, 1'b0, 1'b0, 2'd2);
        expect_at(b + 72, "r2_fail", 3'd4, 1'b1, 1'b0, 1'b1, 2'd2);
        expect_at(b + 80, "r2_fail_held", 3'd4, 1'b1, 1'b0, 1'b1, 2'd2);
        steps(80);

        // Restart from FAIL, then a normal lock
        b = edge_n;
        restart = 1'b1;
        expect_at(b + 1, "restart", 3'd0, 1'b1, 1'b0, 1'b0, 2'd0);
        expect_at(b + 4, "rs_hold", 3'd0, 1'b1, 1'b0, 1'b0, 2'd0);
        expect_at(b + 5, "rs_wait", 3'd1, 1'b0, 1'b0, 1'b0, 2'd0);
        expect_at(b + 8, "rs_filter", 3'd2, 1'b0, 1'b0, 1'b0, 2'd0);
        expect_at(b + 10, "rs_ready", 3'd3, 1'b0, 1'b1, 1'b0, 2'd0);
        step();
        restart = 1'b0;
        steps(4);
        locked = 1'b1;
        steps(8);

        repeat (2) @(negedge clk);
        #1;
        while (sb.size() > 0) begin
            x = sb.pop_front();
            n_total++;
            $display("FAIL %s never checked: due edge %0d, run ended at edge %0d", x.tag, x.e, edge_n);
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
